str_scroll_reader: RTL and testbench
====================================

Name: str_scroll_reader

Overview:
- Reader side of the nibble-string buffer that the string-entry/search logic writes.
- On request, reads the stored 4-bit characters back through a synchronous read port and scrolls them left across a window of 7-segment digits, one position per scroll tick.
- Sits between the string buffer and the board HEX displays.

Parameters:
- DEPTH, 16: buffer entries; address width AW = $clog2(DEPTH).
- NUM_DIGITS, 4: displayed window width in digits.
- TICK_CYCLES, 25000000: display hold time per window in clk cycles (0.5 s at 50 MHz); must be at least 1.

Ports:
- clk  input  1  system clock (CLOCK_50 domain).
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begin scroll; ignored while busy.
- stop  input  1  one-cycle pulse; abort scroll.
- str_len  input  AW+1  number of valid characters, sampled on accepted start.
- rd_en  output  1  buffer read strobe.
- rd_addr  output  AW  buffer read address.
- rd_data  input  4  buffer data; valid exactly 1 cycle after rd_en.
- busy  output  1  high from accepted start until return to IDLE.
- done  output  1  one-cycle pulse at normal scroll completion.
- hex_win  output  7*NUM_DIGITS  active-low segments {g..a} per digit; the MS digit (top 7 bits) shows str[pos].

Behaviour:
- Reset values: all of the following are 0 or blank:
  - rd_en=0, rd_addr=0, busy=0, done=0.
  - hex_win all 1s (blank).
  - pos=0, tick counter=0.
  - State is IDLE.
- The async reset clears everything mid-operation. No read is issued in the cycle after reset release.
- Latched length: len = min(str_len, DEPTH), taken at the accepted start.
- State machine:
  - IDLE → FETCH on start when len>0.
  - start when len=0: done pulses the next cycle, busy stays 0, no reads, display stays blank.
  - FETCH: NUM_DIGITS consecutive cycles, slot k = 0..NUM_DIGITS-1.
    - If pos+k < len: rd_en=1, rd_addr=pos+k.
    - Otherwise: rd_en=0 and the slot is loaded with blank.
    - rd_data is captured into a shadow register one cycle after each read.
  - CAPT: 1 cycle; captures the last slot.
  - COMMIT: 1 cycle; hex_win <= decoded shadow; tick counter cleared.
  - HOLD: lasts TICK_CYCLES cycles, then:
    - if pos+1 < len: pos++ → FETCH;
    - else → FIN.
  - FIN: done=1 for 1 cycle, hex_win blank, pos=0 → IDLE.
- Timing:
  - First commit is visible NUM_DIGITS+2 cycles after the cycle start is sampled.
  - Commit-to-commit period is TICK_CYCLES+NUM_DIGITS+2 cycles.
  - The previous window stays displayed during FETCH and CAPT.
- stop (any non-IDLE state) → IDLE next cycle: hex_win blank, rd_en=0, busy=0, no done pulse.
- stop and start in the same cycle while IDLE: stop wins, start is ignored.
- start while busy: ignored, with no effect on pos or len.
- Decode: 0–9 and A–F in standard active-low hex font; blank = 7'h7F.
- Address arithmetic: pos+k is computed at AW+1 width, so no wrap-around into low addresses.

Optional Feature:
- Macro: SCROLL_LOOP_EN.
- Defined: after the HOLD of window pos=len-1, pos wraps to 0 and the block returns to FETCH instead of FIN. done never pulses. The block runs until stop or reset. len=0 behaves as without the macro.
- Undefined: single pass as described above.

Decomposition:
- Shared package str_pkg holds:
  - SEG_BLANK = 7'h7F;
  - the 16-entry active-low hex segment constant table;
  - the nibble typedef (4-bit);
  - the state enum {IDLE, FETCH, CAPT, COMMIT, HOLD, FIN}.
- One natural sub-module: hex7seg_dec (4-bit in, 7-bit active-low out, combinational), instantiated NUM_DIGITS times.

Test Plan (TICK_CYCLES=4, NUM_DIGITS=4, DEPTH=16):
- Buffer 1,2,3,4,5 and len=5, start pulse:
  - reads at addr 0..3, with the commit at cycle 6 showing "1234";
  - windows "2345", "345_", "45__", "5___", each committed 10 cycles apart;
  - then done pulses once and the display blanks.
- len=2 holding A,B:
  - first window "AB__" with only 2 rd_en strobes;
  - second window "B___";
  - done pulses; busy falls in the same cycle as the return to IDLE.
- len=0 start:
  - done pulses the next cycle;
  - busy never asserts, rd_en never asserts, hex_win stays 7F per digit.
- stop during HOLD of the second window:
  - next cycle busy=0 and hex_win is all blank;
  - no done pulse;
  - a new start restarts at pos=0.
- Assert reset low mid-FETCH:
  - all outputs return to reset values immediately;
  - after release there is no rd_en until a new start;
  - a start pulse while busy has no effect on the window sequence.
- With SCROLL_LOOP_EN and len=3:
  - the window sequence repeats indefinitely, with the "123_" window returning after "3___";
  - done never pulses; stop terminates the loop.

Source files
------------

// File: rtl/str_pkg.sv
// -----------------------------------------------------------------------------
// str_pkg
// Shared definitions for the nibble-string buffer reader/display path:
//   - nibble_t    : one stored 4-bit character
//   - state_t     : scroll reader state machine encoding
//   - SEG_BLANK   : all segments off (active-low)
//   - SEG_TABLE   : active-low {g..a} hex font for 0-9, A-F
// -----------------------------------------------------------------------------
package str_pkg;

  typedef logic [3:0] nibble_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPT,
    COMMIT,
    HOLD,
    FIN
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
  };

endpackage

// File: rtl/hex7seg_dec.sv
// -----------------------------------------------------------------------------
// hex7seg_dec
// Combinational nibble to 7-segment decoder, active-low {g..a}.
// Ports:
//   i_nib  in  4  character value
//   o_seg  out 7  segment pattern
// -----------------------------------------------------------------------------
import str_pkg::*;

module hex7seg_dec (
  input  nibble_t     i_nib,
  output logic [6:0]  o_seg
);

  always_comb begin
    o_seg = SEG_TABLE[i_nib];
  end

endmodule

// File: rtl/str_scroll_reader.sv
// -----------------------------------------------------------------------------
// str_scroll_reader
// Reads the stored nibble string through a synchronous-read port and scrolls it
// left across a NUM_DIGITS-wide 7-segment window, one position per tick.
//
// Parameters:
//   DEPTH        buffer entries (AW = $clog2(DEPTH))
//   NUM_DIGITS   displayed window width
//   TICK_CYCLES  hold time per window in clk cycles (>= 1)
// Ports:
//   clk      in   1              system clock
//   reset    in   1              asynchronous, active-low reset
//   start    in   1              begin scroll (ignored while busy)
//   stop     in   1              abort scroll (wins over start)
//   str_len  in   AW+1           valid characters, sampled on accepted start
//   rd_en    out  1              buffer read strobe
//   rd_addr  out  AW             buffer read address
//   rd_data  in   4              buffer data, valid 1 cycle after rd_en
//   busy     out  1              scroll in progress
//   done     out  1              one-cycle pulse at normal completion
//   hex_win  out  7*NUM_DIGITS   active-low segments, MS digit = str[pos]
// Build option:
//   SCROLL_LOOP_EN  when defined, the scroll wraps to pos=0 forever (no done)
// -----------------------------------------------------------------------------
import str_pkg::*;

module str_scroll_reader #(
  parameter int DEPTH       = 16,
  parameter int NUM_DIGITS  = 4,
  parameter int TICK_CYCLES = 25000000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       stop,
  input  logic [$clog2(DEPTH):0]     str_len,
  output logic                       rd_en,
  output logic [$clog2(DEPTH)-1:0]   rd_addr,
  input  nibble_t                    rd_data,
  output logic                       busy,
  output logic                       done,
  output logic [7*NUM_DIGITS-1:0]    hex_win
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  localparam logic [AW:0]   LEN_MAX   = (AW+1)'(DEPTH);
  localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_DIGITS - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

`ifdef SCROLL_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  state_t                  r_state;
  logic [AW:0]             r_pos;
  logic [AW:0]             r_len;
  logic [SW-1:0]           r_slot;
  logic [TW-1:0]           r_tick;
  logic                    r_cap_act;
  logic                    r_cap_rd;
  logic [SW-1:0]           r_cap_slot;
  logic [NUM_DIGITS-1:0]   r_sh_vld;
  nibble_t                 r_sh_nib [NUM_DIGITS];
  logic                    r_rd_en;
  logic [AW-1:0]           r_rd_addr;
  logic                    r_busy;
  logic                    r_done;
  logic [7*NUM_DIGITS-1:0] r_hex;

  logic [AW:0]             w_len_in;
  logic [AW:0]             w_pos_inc;
  logic                    w_more;
  logic                    w_hold_end;
  logic [AW:0]             w_fpos;
  logic [SW-1:0]           w_fslot;
  logic [AW:0]             w_flen;
  logic [AW:0]             w_fidx;
  logic                    w_frd;
  logic [6:0]              w_seg [NUM_DIGITS];
  logic [7*NUM_DIGITS-1:0] w_win;

  always_comb begin
    w_len_in   = (str_len > LEN_MAX) ? LEN_MAX : str_len;
    w_pos_inc  = r_pos + 1'b1;
    w_more     = (w_pos_inc < r_len);
    w_hold_end = (r_tick == TICK_LAST);
  end

  // Position/slot of the read issued on the coming edge. Computed at AW+1
  // width so pos+k past the string end never aliases a low address.
  always_comb begin
    w_fpos  = r_pos;
    w_fslot = '0;
    w_flen  = r_len;
    case (r_state)
      IDLE: begin
        w_fpos = '0;
        w_flen = w_len_in;
      end
      FETCH:   w_fslot = r_slot + 1'b1;
      HOLD:    w_fpos  = w_more ? w_pos_inc : '0;
      default: ;
    endcase
    w_fidx = w_fpos + (AW+1)'(w_fslot);
    w_frd  = (w_fidx < w_flen);
  end

  // Slot 0 lands in the most significant digit; unread slots show blank.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    hex7seg_dec u_dec (
      .i_nib (r_sh_nib[i]),
      .o_seg (w_seg[i])
    );
    assign w_win[7*(NUM_DIGITS-i)-1 -: 7] = r_sh_vld[i] ? w_seg[i] : SEG_BLANK;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_pos      <= '0;
      r_len      <= '0;
      r_slot     <= '0;
      r_tick     <= '0;
      r_cap_act  <= 1'b0;
      r_cap_rd   <= 1'b0;
      r_cap_slot <= '0;
      r_sh_vld   <= '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) r_sh_nib[i] <= '0;
      r_rd_en    <= 1'b0;
      r_rd_addr  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_hex      <= '1;
    end else begin
      r_done    <= 1'b0;
      r_cap_act <= 1'b0;

      // Read data returns one cycle after the strobe; the slot tag follows it.
      if (r_cap_act) begin
        r_sh_vld[r_cap_slot] <= r_cap_rd;
        r_sh_nib[r_cap_slot] <= rd_data;
      end

      if (stop && (r_state != IDLE)) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
        r_rd_en <= 1'b0;
        r_hex   <= '1;
        r_pos   <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start && !stop) begin
              if (w_len_in == '0) begin
                r_done <= 1'b1;
              end else begin
                r_len   <= w_len_in;
                r_pos   <= '0;
                r_slot  <= '0;
                r_busy  <= 1'b1;
                r_state <= FETCH;
                r_rd_en <= w_frd;
                if (w_frd) r_rd_addr <= w_fidx[AW-1:0];
              end
            end
          end

          FETCH: begin
            r_cap_act  <= 1'b1;
            r_cap_slot <= r_slot;
            r_cap_rd   <= r_rd_en;
            if (r_slot == SLOT_LAST) begin
              r_rd_en <= 1'b0;
              r_state <= CAPT;
            end else begin
              r_slot  <= w_fslot;
              r_rd_en <= w_frd;
              if (w_frd) r_rd_addr <= w_fidx[AW-1:0];
            end
          end

          CAPT: r_state <= COMMIT;

          COMMIT: begin
            r_hex   <= w_win;
            r_tick  <= '0;
            r_state <= HOLD;
          end

          HOLD: begin
            if (!w_hold_end) begin
              r_tick <= r_tick + 1'b1;
            end else if (w_more || LOOP) begin
              r_pos   <= w_fpos;
              r_slot  <= '0;
              r_state <= FETCH;
              r_rd_en <= w_frd;
              if (w_frd) r_rd_addr <= w_fidx[AW-1:0];
            end else begin
              r_done  <= 1'b1;
              r_hex   <= '1;
              r_pos   <= '0;
              r_state <= FIN;
            end
          end

          FIN: begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end

          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign rd_en   = r_rd_en;
  assign rd_addr = r_rd_addr;
  assign busy    = r_busy;
  assign done    = r_done;
  assign hex_win = r_hex;

endmodule

// File: tb/tb_str_scroll_reader.sv
// -----------------------------------------------------------------------------
// tb_str_scroll_reader
// Drives str_scroll_reader against a behavioural buffer and a timing model of
// the scrolled display (window p committed NUM_DIGITS+2 cycles after start,
// then every TICK_CYCLES+NUM_DIGITS+2 cycles).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_str_scroll_reader;

  localparam int DEPTH       = 16;
  localparam int NUM_DIGITS  = 4;
  localparam int TICK_CYCLES = 4;
  localparam int AW          = 4;
  localparam int PER         = TICK_CYCLES + NUM_DIGITS + 2;
  localparam int FIRST       = NUM_DIGITS + 2;
  localparam int HW          = 7 * NUM_DIGITS;

`ifdef SCROLL_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          stop  = 1'b0;
  logic [AW:0]   str_len = '0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [3:0]    rd_data = '0;
  logic          busy;
  logic          done;
  logic [HW-1:0] hex_win;

  logic [3:0]    mem  [DEPTH];
  logic [6:0]    font [16];

  int unsigned   n_checks = 0;
  int unsigned   n_fail   = 0;

  always #5 clk = ~clk;

  // Synchronous-read string buffer.
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  str_scroll_reader #(
    .DEPTH       (DEPTH),
    .NUM_DIGITS  (NUM_DIGITS),
    .TICK_CYCLES (TICK_CYCLES)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .stop    (stop),
    .str_len (str_len),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy),
    .done    (done),
    .hex_win (hex_win)
  );

  // ---------------- reference model (n = edges after the accepting edge) ----
  function automatic int eff_len(input int s);
    return (s > DEPTH) ? DEPTH : s;
  endfunction

  function automatic int win_pos(input int L, input int n);
    int w;
    w = n / PER;
    return LOOP ? (w % L) : w;
  endfunction

  function automatic bit exp_busy(input int L, input int n);
    return (L > 0) && (LOOP || n <= PER * L);
  endfunction

  function automatic bit exp_done(input int L, input int n);
    if (L == 0) return n == 0;
    return !LOOP && (n == PER * L);
  endfunction

  function automatic bit exp_rd(input int L, input int n);
    int ph;
    ph = n % PER;
    if (L == 0 || (!LOOP && n >= PER * L)) return 1'b0;
    return (ph < NUM_DIGITS) && (win_pos(L, n) + ph < L);
  endfunction

  function automatic int exp_addr(input int L, input int n);
    return win_pos(L, n) + (n % PER);
  endfunction

  function automatic logic [HW-1:0] exp_hex(input int L, input int n);
    logic [HW-1:0] r;
    int p;
    r = '1;
    if (L == 0 || n < FIRST || (!LOOP && n >= PER * L)) return r;
    p = win_pos(L, n - FIRST);
    for (int k = 0; k < NUM_DIGITS; k++)
      if (p + k < L) r[7*(NUM_DIGITS-k)-1 -: 7] = font[mem[p+k]];
    return r;
  endfunction

  function automatic int run_len(input int L);
    return LOOP ? (2 * PER * L + PER) : (PER * L + 3);
  endfunction

  // ---------------- stimulus helpers -----------------------------------------
  task automatic kick(input int s);
    start   = 1'b1;
    str_len = (AW+1)'(s);
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic settle();
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) mem[i] = 4'($urandom);
  endtask

  // ---------------- scenarios -----------------------------------------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (rd_en !== 1'b0)   begin n_fail++; $display("FAIL reset_rd_en got %b want 0", rd_en); end
    n_checks++; if (rd_addr !== '0)   begin n_fail++; $display("FAIL reset_rd_addr got %h want 0", rd_addr); end
    n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0)    begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (hex_win !== '1)   begin n_fail++; $display("FAIL reset_hex got %h want all-ones", hex_win); end
    @(negedge clk) reset = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL post_reset_rd_en got %b want 0", rd_en); end
    end
  endtask

  task automatic test_pattern();
    int L;
    fill_random();
    for (int i = 0; i < 5; i++) mem[i] = 4'(i + 1);
    L = 5;
    kick(5);
    for (int n = 0; n < run_len(L); n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      n_checks++; if (hex_win !== exp_hex(L, n)) begin n_fail++; $display("FAIL pat_hex n=%0d got %h want %h", n, hex_win, exp_hex(L, n)); end
      n_checks++; if (busy !== exp_busy(L, n)) begin n_fail++; $display("FAIL pat_busy n=%0d got %b want %b", n, busy, exp_busy(L, n)); end
      n_checks++; if (done !== exp_done(L, n)) begin n_fail++; $display("FAIL pat_done n=%0d got %b want %b", n, done, exp_done(L, n)); end
      n_checks++; if (rd_en !== exp_rd(L, n)) begin n_fail++; $display("FAIL pat_rd_en n=%0d got %b want %b", n, rd_en, exp_rd(L, n)); end
      if (exp_rd(L, n)) begin
        n_checks++; if (rd_addr !== 4'(exp_addr(L, n))) begin n_fail++; $display("FAIL pat_addr n=%0d got %0d want %0d", n, rd_addr, exp_addr(L, n)); end
      end
      if (n == FIRST) begin
        n_checks++; if (hex_win !== {7'h79, 7'h24, 7'h30, 7'h19}) begin n_fail++; $display("FAIL pat_1234 got %h want %h", hex_win, {7'h79, 7'h24, 7'h30, 7'h19}); end
      end
    end
    settle();
  endtask

  task automatic test_short();
    int L;
    int strobes;
    fill_random();
    mem[0] = 4'hA;
    mem[1] = 4'hB;
    L = 2;
    strobes = 0;
    kick(2);
    for (int n = 0; n < run_len(L); n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      if (n < PER && rd_en === 1'b1) strobes++;
      n_checks++; if (hex_win !== exp_hex(L, n)) begin n_fail++; $display("FAIL short_hex n=%0d got %h want %h", n, hex_win, exp_hex(L, n)); end
      n_checks++; if (busy !== exp_busy(L, n)) begin n_fail++; $display("FAIL short_busy n=%0d got %b want %b", n, busy, exp_busy(L, n)); end
      n_checks++; if (done !== exp_done(L, n)) begin n_fail++; $display("FAIL short_done n=%0d got %b want %b", n, done, exp_done(L, n)); end
      n_checks++; if (rd_en !== exp_rd(L, n)) begin n_fail++; $display("FAIL short_rd_en n=%0d got %b want %b", n, rd_en, exp_rd(L, n)); end
    end
    n_checks++; if (strobes != 2) begin n_fail++; $display("FAIL short_strobes got %0d want 2", strobes); end
    settle();
  endtask

  task automatic test_len0();
    kick(0);
    for (int n = 0; n < 6; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      n_checks++; if (done !== exp_done(0, n)) begin n_fail++; $display("FAIL len0_done n=%0d got %b want %b", n, done, exp_done(0, n)); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL len0_busy n=%0d got %b want 0", n, busy); end
      n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL len0_rd_en n=%0d got %b want 0", n, rd_en); end
      n_checks++; if (hex_win !== '1) begin n_fail++; $display("FAIL len0_hex n=%0d got %h want all-ones", n, hex_win); end
    end
  endtask

  task automatic test_stop();
    int L;
    int stop_n;
    fill_random();
    L = 5;
    stop_n = PER + FIRST + 2;   // inside HOLD of the second window
    kick(5);
    for (int n = 0; n < stop_n + 8; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      if (n < stop_n) begin
        n_checks++; if (hex_win !== exp_hex(L, n)) begin n_fail++; $display("FAIL stop_hex n=%0d got %h want %h", n, hex_win, exp_hex(L, n)); end
        n_checks++; if (busy !== exp_busy(L, n)) begin n_fail++; $display("FAIL stop_busy n=%0d got %b want %b", n, busy, exp_busy(L, n)); end
      end else begin
        n_checks++; if (hex_win !== '1) begin n_fail++; $display("FAIL stop_blank n=%0d got %h want all-ones", n, hex_win); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_idle n=%0d got %b want 0", n, busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL stop_done n=%0d got %b want 0", n, done); end
        n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL stop_rd_en n=%0d got %b want 0", n, rd_en); end
      end
      stop = (n + 1 == stop_n);
    end
    stop = 1'b0;
    // Restart must begin again from position 0.
    kick(5);
    for (int n = 0; n < PER + FIRST + 1; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      n_checks++; if (hex_win !== exp_hex(L, n)) begin n_fail++; $display("FAIL restart_hex n=%0d got %h want %h", n, hex_win, exp_hex(L, n)); end
      n_checks++; if (rd_en !== exp_rd(L, n)) begin n_fail++; $display("FAIL restart_rd_en n=%0d got %b want %b", n, rd_en, exp_rd(L, n)); end
      if (exp_rd(L, n)) begin
        n_checks++; if (rd_addr !== 4'(exp_addr(L, n))) begin n_fail++; $display("FAIL restart_addr n=%0d got %0d want %0d", n, rd_addr, exp_addr(L, n)); end
      end
    end
    settle();
  endtask

  task automatic test_reset_mid();
    int L;
    fill_random();
    kick(4);
    @(posedge clk); #1;        // mid-FETCH
    #2 reset = 1'b0;
    #1;
    n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL arst_rd_en got %b want 0", rd_en); end
    n_checks++; if (rd_addr !== '0) begin n_fail++; $display("FAIL arst_rd_addr got %h want 0", rd_addr); end
    n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL arst_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0)  begin n_fail++; $display("FAIL arst_done got %b want 0", done); end
    n_checks++; if (hex_win !== '1) begin n_fail++; $display("FAIL arst_hex got %h want all-ones", hex_win); end
    @(negedge clk) reset = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL arst_release_rd_en n=%0d got %b want 0", n, rd_en); end
      n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL arst_release_busy n=%0d got %b want 0", n, busy); end
    end
    // New scroll with a stray start (different length) while busy.
    L = 3;
    kick(3);
    for (int n = 0; n < run_len(L); n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      n_checks++; if (hex_win !== exp_hex(L, n)) begin n_fail++; $display("FAIL busystart_hex n=%0d got %h want %h", n, hex_win, exp_hex(L, n)); end
      n_checks++; if (done !== exp_done(L, n)) begin n_fail++; $display("FAIL busystart_done n=%0d got %b want %b", n, done, exp_done(L, n)); end
      n_checks++; if (rd_en !== exp_rd(L, n)) begin n_fail++; $display("FAIL busystart_rd_en n=%0d got %b want %b", n, rd_en, exp_rd(L, n)); end
      start = (n == 11);
      str_len = (n == 11) ? 5'd9 : 5'd3;
    end
    start = 1'b0;
    settle();
  endtask

  task automatic test_loop();
    int L;
    fill_random();
    for (int i = 0; i < 3; i++) mem[i] = 4'(i + 1);
    L = 3;
    kick(3);
    for (int n = 0; n < run_len(L); n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      n_checks++; if (hex_win !== exp_hex(L, n)) begin n_fail++; $display("FAIL loop_hex n=%0d got %h want %h", n, hex_win, exp_hex(L, n)); end
      n_checks++; if (done !== exp_done(L, n)) begin n_fail++; $display("FAIL loop_done n=%0d got %b want %b", n, done, exp_done(L, n)); end
      n_checks++; if (busy !== exp_busy(L, n)) begin n_fail++; $display("FAIL loop_busy n=%0d got %b want %b", n, busy, exp_busy(L, n)); end
    end
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL loop_stop_busy got %b want 0", busy); end
    n_checks++; if (hex_win !== '1) begin n_fail++; $display("FAIL loop_stop_hex got %h want all-ones", hex_win); end
    n_checks++; if (done !== 1'b0)  begin n_fail++; $display("FAIL loop_stop_done got %b want 0", done); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int s;
    int L;
    for (int it = 0; it < 4; it++) begin
      fill_random();
      s = (it == 0) ? (2 * DEPTH - 1) : $urandom_range(1, 2 * DEPTH - 1);
      L = eff_len(s);
      kick(s);
      for (int n = 0; n < run_len(L); n++) begin
        if (n > 0) begin @(posedge clk); #1; end
        n_checks++; if (hex_win !== exp_hex(L, n)) begin n_fail++; $display("FAIL rnd_hex s=%0d n=%0d got %h want %h", s, n, hex_win, exp_hex(L, n)); end
        n_checks++; if (busy !== exp_busy(L, n)) begin n_fail++; $display("FAIL rnd_busy s=%0d n=%0d got %b want %b", s, n, busy, exp_busy(L, n)); end
        n_checks++; if (done !== exp_done(L, n)) begin n_fail++; $display("FAIL rnd_done s=%0d n=%0d got %b want %b", s, n, done, exp_done(L, n)); end
        n_checks++; if (rd_en !== exp_rd(L, n)) begin n_fail++; $display("FAIL rnd_rd_en s=%0d n=%0d got %b want %b", s, n, rd_en, exp_rd(L, n)); end
        if (exp_rd(L, n)) begin
          n_checks++; if (rd_addr !== 4'(exp_addr(L, n))) begin n_fail++; $display("FAIL rnd_addr s=%0d n=%0d got %0d want %0d", s, n, rd_addr, exp_addr(L, n)); end
        end
      end
      settle();
    end
  endtask

  initial begin
    font = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    fill_random();
    test_reset();
    test_pattern();
    test_short();
    test_len0();
    test_stop();
    test_reset_mid();
    test_loop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
